// File: rtl/ntt_twiddle_seq.sv
// ntt_twiddle_seq: stage-ordered twiddle-factor sequencer for the Dilithium NTT.
// For each stage (mid = 1,2,4,..,2^(NUM_STAGES-1)) it requests the base root g1
// from an external registered ROM. It then streams w_j = g1^j mod Q for
// j = 0..mid-1 over a valid/ready handshake.
// Optional feature macro: TWSEQ_SELFCHECK_EN. When it is defined, each stage
// ends with a g1^mid == Q-1 check and LOAD rejects g1 == 1. Either failure sets
// a sticky err and aborts the sequence.
module ntt_twiddle_seq #(
  parameter int unsigned Q          = 8380417,
  parameter int unsigned NUM_STAGES = 8,
  parameter int unsigned MUL_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [8:0]  mid,
  input  logic [23:0] g1,
  output logic [23:0] tw,
  output logic        tw_valid,
  input  logic        tw_ready,
  output logic        tw_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [23:0] Q24      = 24'(Q);
  localparam logic [23:0] QM1      = 24'(Q - 1);
  localparam logic [8:0]  MID_LAST = 9'(1 << (NUM_STAGES - 1));
  localparam int unsigned CW       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_LOAD, S_EMIT, S_MUL, S_CHECK, S_NEXT
  } state_t;

  // The folding constants rely on Q = 2^23 - 2^13 + 1, i.e. 2^23 == 2^13 - 1 (mod Q).
  // Three folds bring a 48-bit product below 2Q, so one conditional subtract finishes.
  function automatic logic [23:0] mod_mul(input logic [23:0] a, input logic [23:0] b);
    logic [47:0] p;
    logic [38:0] f1;
    logic [29:0] f2;
    logic [23:0] f3;
    p  = 48'(a) * 48'(b);
    f1 = ({14'd0, p[47:23]} << 13) - {14'd0, p[47:23]} + {16'd0, p[22:0]};
    f2 = ({14'd0, f1[38:23]} << 13) - {14'd0, f1[38:23]} + {7'd0, f1[22:0]};
    f3 = ({17'd0, f2[29:23]} << 13) - {17'd0, f2[29:23]} + {1'b0, f2[22:0]};
    if (f3 >= Q24) begin
      f3 = f3 - Q24;
    end
    return f3;
  endfunction

  state_t        state_q, state_d;
  logic [8:0]    mid_q, mid_d;
  logic [23:0]   g_q, g_d;
  logic [23:0]   w_q, w_d;
  logic [7:0]    j_q, j_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tw_valid_q, tw_valid_d;
  logic          tw_last_q, tw_last_d;
  logic [23:0]   prod;
`ifdef TWSEQ_SELFCHECK_EN
  logic          err_q, err_d;
`endif

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    state_d = state_q;
    mid_d   = mid_q;
    g_d     = g_q;
    w_d     = w_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef TWSEQ_SELFCHECK_EN
    err_d   = err_q;
`endif
    prod    = mod_mul(w_q, g_q);
    case (state_q)
      S_IDLE: begin
        // A start arriving while done is still high belongs to the old run.
        if (start && !done_q) begin
          mid_d   = 9'd1;
          busy_d  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: state_d = S_LOAD;
      S_LOAD: begin
        g_d     = g1;
        w_d     = 24'd1;
        j_d     = 8'd0;
        state_d = S_EMIT;
`ifdef TWSEQ_SELFCHECK_EN
        if (g1 == 24'd1) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
`endif
      end
      S_EMIT: begin
        if (tw_ready) begin
          cnt_d = '0;
          if ({1'b0, j_q} == mid_q - 9'd1) begin
`ifdef TWSEQ_SELFCHECK_EN
            state_d = S_CHECK;
`else
            state_d = S_NEXT;
`endif
          end else begin
            j_d     = j_q + 8'd1;
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_LAST) begin
          w_d     = prod;
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef TWSEQ_SELFCHECK_EN
      S_CHECK: begin
        if (cnt_q == CNT_LAST) begin
          if (prod != QM1) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_NEXT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_NEXT: begin
        if (mid_q == MID_LAST) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          mid_d   = mid_q << 1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    tw_valid_d = (state_d == S_EMIT);
    tw_last_d  = tw_valid_d && ({1'b0, j_d} == mid_d - 9'd1);
  end

  // State and registered outputs; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mid_q      <= 9'd0;
      g_q        <= 24'd0;
      w_q        <= 24'd0;
      j_q        <= 8'd0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tw_valid_q <= 1'b0;
      tw_last_q  <= 1'b0;
`ifdef TWSEQ_SELFCHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mid_q      <= mid_d;
      g_q        <= g_d;
      w_q        <= w_d;
      j_q        <= j_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tw_valid_q <= tw_valid_d;
      tw_last_q  <= tw_last_d;
`ifdef TWSEQ_SELFCHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign mid      = mid_q;
  assign tw       = w_q;
  assign tw_valid = tw_valid_q;
  assign tw_last  = tw_last_q;
  assign busy     = busy_q;
  assign done     = done_q;
`ifdef TWSEQ_SELFCHECK_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule
